// File: rtl/cmd_fetch_ctrl_if.sv
// Command fetch bus bundle.
// The bundle carries three groups of signals:
//   - the command handshake to the processor core,
//   - the host loader write request,
//   - the command memory port.
// The master modport is the fetch controller's view.
// The slave modport is the view of the core, the host loader and the memory together.
interface cmd_fetch_ctrl_if #(
    parameter int CMD_WIDTH  = 128,
    parameter int ADDR_WIDTH = 8
);
    // core handshake
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [CMD_WIDTH-1:0]  cmd_data;
    logic [ADDR_WIDTH-1:0] cmd_addr;

    // host loader write request
    logic                  host_wr_en;
    logic [ADDR_WIDTH-1:0] host_wr_addr;
    logic [CMD_WIDTH-1:0]  host_wr_data;
    logic                  host_wr_ack;

    // command memory port (registered read address, combinational data out)
    logic [ADDR_WIDTH-1:0] mem_read_address;
    logic                  mem_write_enable;
    logic [ADDR_WIDTH-1:0] mem_write_address;
    logic [CMD_WIDTH-1:0]  mem_cmd_in;
    logic [CMD_WIDTH-1:0]  mem_cmd_out;

    modport master (
        output cmd_valid, cmd_data, cmd_addr,
        input  cmd_ready,
        input  host_wr_en, host_wr_addr, host_wr_data,
        output host_wr_ack,
        output mem_read_address, mem_write_enable, mem_write_address, mem_cmd_in,
        input  mem_cmd_out
    );

    modport slave (
        input  cmd_valid, cmd_data, cmd_addr,
        output cmd_ready,
        output host_wr_en, host_wr_addr, host_wr_data,
        input  host_wr_ack,
        input  mem_read_address, mem_write_enable, mem_write_address, mem_cmd_in,
        output mem_cmd_out
    );
endinterface

// File: rtl/cmd_fetch_ctrl.sv
// Command fetch sequencer and command-memory port arbiter.
// The controller drives the memory read address as a program counter.
// It presents each command to the core over a valid/ready handshake.
// It supports start, jump and halt.
// It shares the memory write port with the host loader.
//
// Optional feature, enabled by defining CMD_FETCH_LIVE_WRITE_EN:
//   - When defined, host writes are accepted in every state (live patching).
//   - When undefined, host writes are accepted only while IDLE.
module cmd_fetch_ctrl #(
    parameter int CMD_WIDTH  = 128,
    parameter int ADDR_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic                  halt,
    input  logic                  jump_en,
    input  logic [ADDR_WIDTH-1:0] jump_addr,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  cmd_count,
    cmd_fetch_ctrl_if.master      bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] pc_inc;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  cmd_valid_q;
    logic                  busy_q;
    logic                  fire;
    logic                  wr_allowed;

    assign fire   = cmd_valid_q & bus.cmd_ready;
    // Natural wrap from the last word back to 0.
    assign pc_inc = pc + ADDR_WIDTH'(1);

    // Next read address.
    // pc is loaded with this value every cycle, so the memory's registered
    // address always equals pc and mem_cmd_out always holds the word at pc.
    // Reset forces 0 so the memory address register and pc stay in step.
    // Halt outranks jump: once halted, a jump request is ignored.
    always_comb begin
        rd_addr = pc;
        if (reset) begin
            rd_addr = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) rd_addr = start_addr;
                end
                RUN: begin
                    if (halt)         rd_addr = fire ? pc_inc : pc;
                    else if (jump_en) rd_addr = jump_addr;
                    else if (fire)    rd_addr = pc_inc;
                end
                default: rd_addr = pc;
            endcase
        end
    end

    // Sequencer FSM with registered handshake/status outputs and the delivered-command counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            pc          <= '0;
            cmd_count   <= '0;
            cmd_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            pc <= rd_addr;
            // fire cannot occur in IDLE, so this never collides with the start clear.
            if (fire && (cmd_count != {CNT_WIDTH{1'b1}}))
                cmd_count <= cmd_count + CNT_WIDTH'(1);
            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= RUN;
                        cmd_valid_q <= 1'b1;
                        busy_q      <= 1'b1;
                        cmd_count   <= '0;
                    end
                end
                RUN: begin
                    if (halt) begin
                        if (fire) begin
                            state       <= IDLE;
                            cmd_valid_q <= 1'b0;
                            busy_q      <= 1'b0;
                        end else begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (fire) begin
                        state       <= IDLE;
                        cmd_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    cmd_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    // Host write admission.
    // A write to the word at pc shows up on cmd_data the following cycle,
    // because the memory read is combinational from the held address.
`ifdef CMD_FETCH_LIVE_WRITE_EN
    assign wr_allowed = 1'b1;
`else
    assign wr_allowed = (state == IDLE);
`endif

    assign bus.host_wr_ack       = bus.host_wr_en & wr_allowed & ~reset;
    assign bus.mem_write_enable  = bus.host_wr_ack;
    assign bus.mem_write_address = bus.host_wr_addr;
    assign bus.mem_cmd_in        = bus.host_wr_data;
    assign bus.mem_read_address  = rd_addr;

    assign bus.cmd_valid = cmd_valid_q;
    assign bus.cmd_data  = bus.mem_cmd_out;
    assign bus.cmd_addr  = pc;
    assign busy          = busy_q;

endmodule
